apb_reg_completer: RTL and testbench
====================================

APB_REG_COMPLETER -- requirements
Module: apb_reg_completer

Interface
REQ-001 SHALL have parameter APB_AW, default 32, address width.
REQ-002 SHALL have parameter APB_DW, default 32, data width (32 only).
REQ-003 SHALL have parameter APB_SW, default APB_DW/8, write-strobe width.
REQ-004 SHALL have parameter NUM_REGS, default 16, register count (1..256).
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, access-phase wait states (0..15).
REQ-006 SHALL have port ckApb  input  1  APB clock; all logic on its rising edge.
REQ-007 SHALL have port arstApb  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port apbPAddr  input  APB_AW  address.
REQ-009 SHALL have port apbPProt  input  3  protection attributes.
REQ-010 SHALL have ports apbPSel, apbPEnable, apbPWrite  input  1 each  select, enable, write.
REQ-011 SHALL have port apbPWData  input  APB_DW  write data.
REQ-012 SHALL have port apbPStrb  input  APB_SW  byte-lane strobes.
REQ-013 SHALL have port apbPRData  output  APB_DW  read data.
REQ-014 SHALL have ports apbPReady, apbPSlvErr  output  1 each  transfer done, transfer error.
REQ-015 SHALL have port regQ  output  NUM_REGS*APB_DW  flattened register contents; reg i at bits [i*APB_DW +: APB_DW].

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> IDLE.
- IDLE -> ACCESS when apbPSel=1 and apbPEnable=0; load waitCnt with WAIT_CYCLES.
- ACCESS: decrement waitCnt each cycle while it is nonzero.
REQ-017 SHALL drive apbPReady=1 only in ACCESS with waitCnt=0 and apbPSel=apbPEnable=1; latency is WAIT_CYCLES+1 cycles after the setup cycle.
REQ-018 SHALL return to IDLE on the cycle after apbPReady=1; back-to-back setup on that next cycle SHALL be accepted.
REQ-019 SHALL decode index = apbPAddr[APB_AW-1:2].
REQ-020 SHALL flag an error when apbPAddr[1:0]!=0 or index>=NUM_REGS.
REQ-021 SHALL, on a write completion without error, update byte lane b of the register only where apbPStrb[b]=1; apbPStrb=0 SHALL leave the register unchanged.
REQ-022 SHALL, on a read completion without error, drive apbPRData with the register value in the apbPReady cycle; reads SHALL ignore apbPStrb.
REQ-023 SHALL, on an error, assert apbPSlvErr with apbPReady, perform no write, and drive apbPRData=0.
REQ-024 SHALL hold apbPRData=0 and apbPSlvErr=0 whenever apbPReady=0.
REQ-025 SHALL return to IDLE with no write if apbPSel drops during ACCESS (protocol violation).
REQ-026 SHALL sample address, direction and data in the completion cycle (APB keeps them stable through the transfer).

Reset
REQ-027 SHALL, while arstApb=1, force: state IDLE, waitCnt 0, all registers 0, apbPReady 0, apbPSlvErr 0, apbPRData 0.
REQ-028 SHALL abandon an in-progress transfer without a write when reset asserts mid-ACCESS.
REQ-029 SHALL accept a setup on the first rising edge after arstApb deasserts.

Configuration
REQ-030 SHALL, with APB_REG_COMPLETER_PROT_EN defined, also flag an error (per REQ-023) when apbPProt[1]=1 (non-secure); no write is performed.
REQ-031 SHALL, without APB_REG_COMPLETER_PROT_EN, ignore apbPProt entirely.

Structure
REQ-032 SHALL place in package apb_reg_completer_pkg:
- the FSM state enum typedef;
- the byte-offset width constant (2);
- the PPROT non-secure bit index constant (1).
REQ-033 SHALL put register storage and strobe-masked writes in one sub-module, apb_reg_bank; the FSM, wait counter and decode SHALL stay in apb_reg_completer.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=0, write 0xDEADBEEF to 0x04 with strobe 0xF, then read 0x04 -> apbPReady in first access cycle, read returns 0xDEADBEEF, apbPSlvErr=0.
REQ-035 SHALL cover: WAIT_CYCLES=3, read 0x00 -> apbPReady high exactly 4 cycles after setup, apbPRData=0 after reset.
REQ-036 SHALL cover: write 0x11223344 to 0x08 with strobe 0x5 over 0xFFFFFFFF -> read 0xFF22FF44.
REQ-037 SHALL cover: NUM_REGS=16, write to 0x40 and read 0x02 -> apbPSlvErr=1 with apbPReady, apbPRData=0, regQ unchanged.
REQ-038 SHALL cover: PROT_EN build, write 0x5A5A5A5A to 0x0C with apbPProt=3'b010 -> apbPSlvErr=1, reg 3 stays 0; apbPProt=3'b000 -> write succeeds.
REQ-039 SHALL cover: arstApb pulsed during ACCESS with WAIT_CYCLES=5 -> apbPReady never asserts, state IDLE, regQ all zero.

Source files
------------

// File: rtl/apb_reg_completer_pkg.sv
// ---------------------------------------------------------------------------
// apb_reg_completer_pkg
// Shared types and constants for the APB register completer.
//   apb_state_e      : completer FSM states (IDLE, ACCESS)
//   BYTE_OFF_W       : number of byte-offset address bits below the word index
//   PPROT_NS_BIT     : index of the non-secure bit within PPROT
//   BYTE_W           : width of one write-strobe lane
//   idx_width()      : register-index width for a given register count
// ---------------------------------------------------------------------------
package apb_reg_completer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam int BYTE_OFF_W   = 2;
    localparam int PPROT_NS_BIT = 1;
    localparam int BYTE_W       = 8;

    // A single register still needs a 1-bit index so port widths stay legal.
    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// ---------------------------------------------------------------------------
// apb_reg_bank
// Register storage with byte-lane masked writes.
// Ports:
//   ckApb    in   clock, rising edge
//   arstApb  in   asynchronous active-high reset, clears every register
//   i_we     in   write enable (already qualified: completion, no error)
//   i_idx    in   register index for write and read
//   i_wdata  in   write data
//   i_strb   in   byte-lane strobes, lane b written only when i_strb[b]=1
//   o_rdata  out  contents of register i_idx
//   o_q      out  flattened contents, reg i at [i*APB_DW +: APB_DW]
// ---------------------------------------------------------------------------
module apb_reg_bank
    import apb_reg_completer_pkg::*;
#(
    parameter int APB_DW   = 32,
    parameter int APB_SW   = APB_DW / 8,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                       ckApb,
    input  logic                       arstApb,
    input  logic                       i_we,
    input  logic [IDX_W-1:0]           i_idx,
    input  logic [APB_DW-1:0]          i_wdata,
    input  logic [APB_SW-1:0]          i_strb,
    output logic [APB_DW-1:0]          o_rdata,
    output logic [NUM_REGS*APB_DW-1:0] o_q
);

    logic [APB_DW-1:0] r_regs [NUM_REGS];

    // Register array: cleared on reset, byte-masked update on qualified write.
    always_ff @(posedge ckApb or posedge arstApb) begin
        if (arstApb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_we && (i_idx == IDX_W'(i))) begin
                    for (int b = 0; b < APB_SW; b++) begin
                        if (i_strb[b]) begin
                            r_regs[i][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
                        end
                    end
                end
            end
        end
    end

    // Out-of-range indices are masked to zero by the completer.
    assign o_rdata = r_regs[i_idx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_q[g*APB_DW +: APB_DW] = r_regs[g];
    end

endmodule

// File: rtl/apb_reg_completer.sv
// ---------------------------------------------------------------------------
// apb_reg_completer
// APB completer fronting NUM_REGS 32-bit registers, with WAIT_CYCLES wait
// states in the access phase. Misaligned or out-of-range addresses complete
// with PSLVERR and no write.
// Optional feature: define APB_REG_COMPLETER_PROT_EN to also reject
// non-secure accesses (apbPProt[1]=1) with PSLVERR; otherwise apbPProt is
// ignored.
// Ports:
//   ckApb, arstApb          clock (rising edge), async active-high reset
//   apbPAddr, apbPProt      address, protection attributes
//   apbPSel, apbPEnable     select, enable
//   apbPWrite, apbPWData    direction, write data
//   apbPStrb                byte-lane strobes
//   apbPRData               read data (zero unless a good read completes)
//   apbPReady, apbPSlvErr   transfer done, transfer error
//   regQ                    flattened register contents
// ---------------------------------------------------------------------------
module apb_reg_completer
    import apb_reg_completer_pkg::*;
#(
    parameter int APB_AW      = 32,
    parameter int APB_DW      = 32,
    parameter int APB_SW      = APB_DW / 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                       ckApb,
    input  logic                       arstApb,
    input  logic [APB_AW-1:0]          apbPAddr,
    input  logic [2:0]                 apbPProt,
    input  logic                       apbPSel,
    input  logic                       apbPEnable,
    input  logic                       apbPWrite,
    input  logic [APB_DW-1:0]          apbPWData,
    input  logic [APB_SW-1:0]          apbPStrb,
    output logic [APB_DW-1:0]          apbPRData,
    output logic                       apbPReady,
    output logic                       apbPSlvErr,
    output logic [NUM_REGS*APB_DW-1:0] regQ
);

    localparam int          IDX_W         = idx_width(NUM_REGS);
    localparam int          FULL_IDX_W    = APB_AW - BYTE_OFF_W;
    localparam logic [3:0]  WAIT_CNT_INIT = 4'(WAIT_CYCLES);

    apb_state_e        r_state;
    logic [3:0]        r_wait_cnt;

    logic [FULL_IDX_W-1:0] w_index;
    logic                  w_misaligned;
    logic                  w_idx_oob;
    logic                  w_prot_err;
    logic                  w_unused_prot;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_we;
    logic [APB_DW-1:0]     w_rdata;

    assign w_index      = apbPAddr[APB_AW-1:BYTE_OFF_W];
    assign w_misaligned = |apbPAddr[BYTE_OFF_W-1:0];
    assign w_idx_oob    = (w_index >= FULL_IDX_W'(NUM_REGS));

`ifdef APB_REG_COMPLETER_PROT_EN
    assign w_prot_err    = apbPProt[PPROT_NS_BIT];
    assign w_unused_prot = apbPProt[2] ^ apbPProt[0];
`else
    assign w_prot_err    = 1'b0;
    assign w_unused_prot = ^apbPProt;
`endif

    assign w_err = w_misaligned | w_idx_oob | w_prot_err;

    // Completion needs the wait count exhausted and the bus still in access.
    assign w_ready = (r_state == ST_ACCESS) && (r_wait_cnt == 4'd0)
                     && apbPSel && apbPEnable;
    assign w_we    = w_ready && apbPWrite && !w_err;

    assign apbPReady  = w_ready;
    assign apbPSlvErr = w_ready && w_err;
    assign apbPRData  = (w_ready && !apbPWrite && !w_err) ? w_rdata : '0;

    // Transfer FSM with the access-phase wait counter.
    always_ff @(posedge ckApb or posedge arstApb) begin
        if (arstApb) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (apbPSel && !apbPEnable) begin
                        r_state    <= ST_ACCESS;
                        r_wait_cnt <= WAIT_CNT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (!apbPSel) begin
                        // Requester abandoned the transfer: drop it, no write.
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= 4'd0;
                    end else if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else if (apbPEnable) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    apb_reg_bank #(
        .APB_DW   (APB_DW),
        .APB_SW   (APB_SW),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .ckApb   (ckApb),
        .arstApb (arstApb),
        .i_we    (w_we),
        .i_idx   (w_index[IDX_W-1:0]),
        .i_wdata (apbPWData),
        .i_strb  (apbPStrb),
        .o_rdata (w_rdata),
        .o_q     (regQ)
    );

endmodule

// File: tb/tb_apb_reg_completer.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_completer
// Three completers (WAIT_CYCLES 0, 3, 5) on separate buses. A per-instance
// behavioural model (register array plus "cycles since setup" count) predicts
// every output on every falling edge; directed transfers pin the model with
// literal expectations, then random traffic runs against it.
// ---------------------------------------------------------------------------
module tb_apb_reg_completer;

    localparam int ND = 3;
    localparam int NR = 16;

    logic         ck;
    logic         rst     [ND];
    logic [31:0]  paddr   [ND];
    logic [2:0]   pprot   [ND];
    logic         psel    [ND];
    logic         pen     [ND];
    logic         pwr     [ND];
    logic [31:0]  pwdata  [ND];
    logic [3:0]   pstrb   [ND];
    logic [31:0]  prdata  [ND];
    logic         pready  [ND];
    logic         pslverr [ND];
    logic [511:0] regq    [ND];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int WG = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        apb_reg_completer #(
            .APB_AW(32), .APB_DW(32), .APB_SW(4), .NUM_REGS(NR), .WAIT_CYCLES(WG)
        ) u_dut (
            .ckApb      (ck),
            .arstApb    (rst[g]),
            .apbPAddr   (paddr[g]),
            .apbPProt   (pprot[g]),
            .apbPSel    (psel[g]),
            .apbPEnable (pen[g]),
            .apbPWrite  (pwr[g]),
            .apbPWData  (pwdata[g]),
            .apbPStrb   (pstrb[g]),
            .apbPRData  (prdata[g]),
            .apbPReady  (pready[g]),
            .apbPSlvErr (pslverr[g]),
            .regQ       (regq[g])
        );
    end

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] mdl  [ND][NR];
    bit          busy [ND];
    int          acc  [ND];

    always @(negedge ck) begin
        for (int d = 0; d < ND; d++) begin
            logic         e_err;
            logic         e_rdy;
            logic [511:0] e_q;
            int           idx;
            if (rst[d]) begin
                for (int i = 0; i < NR; i++) mdl[d][i] = 32'h0;
                busy[d] = 1'b0;
                acc[d]  = 0;
            end
            idx   = int'(paddr[d][31:2]);
            e_err = (paddr[d][1:0] != 2'b00) || (idx >= NR);
`ifdef APB_REG_COMPLETER_PROT_EN
            e_err = e_err || pprot[d][1];
`endif
            // Done once the access phase has lasted WAIT_CYCLES extra cycles.
            e_rdy = !rst[d] && busy[d] && (acc[d] >= wait_of(d)) && psel[d] && pen[d];
            chk($sformatf("ready_d%0d", d), 512'(pready[d]), 512'(e_rdy));
            chk($sformatf("slverr_d%0d", d), 512'(pslverr[d]), 512'(e_rdy && e_err));
            if (!e_rdy || e_err)
                chk($sformatf("prdata_zero_d%0d", d), 512'(prdata[d]), 512'h0);
            else if (!pwr[d])
                chk($sformatf("prdata_d%0d", d), 512'(prdata[d]), 512'(mdl[d][idx]));
            e_q = '0;
            for (int i = 0; i < NR; i++) e_q[i*32 +: 32] = mdl[d][i];
            chk($sformatf("regq_d%0d", d), regq[d], e_q);
            // Advance the model to the next rising edge.
            if (!rst[d]) begin
                if (!busy[d]) begin
                    if (psel[d] && !pen[d]) begin
                        busy[d] = 1'b1;
                        acc[d]  = 0;
                    end
                end else if (!psel[d]) begin
                    busy[d] = 1'b0;
                end else if (e_rdy) begin
                    busy[d] = 1'b0;
                    if (pwr[d] && !e_err)
                        for (int b = 0; b < 4; b++)
                            if (pstrb[d][b]) mdl[d][idx][b*8 +: 8] = pwdata[d][b*8 +: 8];
                end else begin
                    acc[d]++;
                end
            end
        end
    end

    // ---------------- drivers (enter and leave 1 time unit after posedge) ----------------
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                        output logic [31:0] rd, output logic er, output int lat);
        paddr[d] = addr; pwr[d] = wr; pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
        psel[d] = 1'b1; pen[d] = 1'b0;
        @(posedge ck); #1;
        pen[d] = 1'b1;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge ck);
            if (pready[d]) begin
                lat = c; rd = prdata[d]; er = pslverr[d];
                break;
            end
        end
        chk($sformatf("ready_within_bound_d%0d", d), 512'(lat != 0), 512'(1'b1));
        @(posedge ck); #1;
        psel[d] = 1'b0; pen[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge ck); #1; end
    endtask

    task automatic abort_xfer(input int d, input logic [31:0] addr, input logic [31:0] wd);
        paddr[d] = addr; pwr[d] = 1'b1; pwdata[d] = wd; pstrb[d] = 4'hF; pprot[d] = 3'b000;
        psel[d] = 1'b1; pen[d] = 1'b0;
        @(posedge ck); #1;
        pen[d] = 1'b1;
        @(posedge ck); #1;
        psel[d] = 1'b0; pen[d] = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0]  rd;
        logic         er;
        int           lat;
        int           seen;
        logic [511:0] q_exp;
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; paddr[d] = 32'h0; pprot[d] = 3'b000; psel[d] = 1'b0;
            pen[d] = 1'b0; pwr[d] = 1'b0; pwdata[d] = 32'h0; pstrb[d] = 4'h0;
        end
        repeat (3) @(posedge ck);
        #1;
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;

        // Setup right on the first edge after reset release; reads zero.
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, lat);
        chk("post_reset_read_lat", 512'(lat), 512'(1));
        chk("post_reset_read_data", 512'(rd), 512'h0);

        // Zero wait states, write then back-to-back read.
        xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, lat);
        chk("w0_write_lat", 512'(lat), 512'(1));
        chk("w0_write_err", 512'(er), 512'(1'b0));
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, lat);
        chk("w0_read_lat", 512'(lat), 512'(1));
        chk("w0_read_data", 512'(rd), 512'(32'hDEADBEEF));
        chk("w0_read_err", 512'(er), 512'(1'b0));

        // Three wait states: ready four cycles after setup.
        xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, rd, er, lat);
        chk("w3_read_lat", 512'(lat), 512'(4));
        chk("w3_read_data", 512'(rd), 512'h0);

        // Partial strobes over all-ones.
        xfer(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, lat);
        xfer(0, 1'b1, 32'h8, 32'h11223344, 4'h5, 3'b000, rd, er, lat);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, lat);
        chk("strobe_merge", 512'(rd), 512'(32'hFF22FF44));

        // Zero strobe leaves the register alone.
        xfer(0, 1'b1, 32'h8, 32'h00000000, 4'h0, 3'b000, rd, er, lat);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, lat);
        chk("zero_strobe", 512'(rd), 512'(32'hFF22FF44));

        // Out-of-range write and misaligned read.
        q_exp = '0;
        q_exp[32 +: 32] = 32'hDEADBEEF;
        q_exp[64 +: 32] = 32'hFF22FF44;
        xfer(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, lat);
        chk("oob_write_err", 512'(er), 512'(1'b1));
        chk("oob_write_regq", regq[0], q_exp);
        xfer(0, 1'b0, 32'h2, 32'h0, 4'h0, 3'b000, rd, er, lat);
        chk("misaligned_read_err", 512'(er), 512'(1'b1));
        chk("misaligned_read_data", 512'(rd), 512'h0);

        // Non-secure write: rejected only with protection checking built in.
        xfer(0, 1'b1, 32'hC, 32'h5A5A5A5A, 4'hF, 3'b010, rd, er, lat);
`ifdef APB_REG_COMPLETER_PROT_EN
        chk("nonsecure_err", 512'(er), 512'(1'b1));
        chk("nonsecure_reg3", 512'(regq[0][96 +: 32]), 512'h0);
`else
        chk("nonsecure_err", 512'(er), 512'(1'b0));
        chk("nonsecure_reg3", 512'(regq[0][96 +: 32]), 512'(32'h5A5A5A5A));
`endif
        xfer(0, 1'b1, 32'hC, 32'h5A5A5A5A, 4'hF, 3'b000, rd, er, lat);
        chk("secure_err", 512'(er), 512'(1'b0));
        chk("secure_reg3", 512'(regq[0][96 +: 32]), 512'(32'h5A5A5A5A));

        // Reset pulse in the middle of a five-wait-state access.
        xfer(2, 1'b1, 32'h10, 32'h12345678, 4'hF, 3'b000, rd, er, lat);
        chk("w5_write_lat", 512'(lat), 512'(6));
        chk("w5_reg4", 512'(regq[2][128 +: 32]), 512'(32'h12345678));
        paddr[2] = 32'h0; pwr[2] = 1'b1; pwdata[2] = 32'hA5A5A5A5; pstrb[2] = 4'hF;
        psel[2] = 1'b1; pen[2] = 1'b0;
        @(posedge ck); #1;
        pen[2] = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ck);
            if (pready[2]) seen++;
            @(posedge ck); #1;
            if (k == 1) rst[2] = 1'b1;
            if (k == 3) rst[2] = 1'b0;
            if (k == 6) begin psel[2] = 1'b0; pen[2] = 1'b0; end
        end
        chk("rst_mid_access_no_ready", 512'(seen), 512'(0));
        chk("rst_mid_access_regq", regq[2], 512'h0);
        xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, lat);
        chk("after_rst_lat", 512'(lat), 512'(6));
        chk("after_rst_data", 512'(rd), 512'h0);

        // Random traffic on every instance.
        for (int d = 0; d < ND; d++) begin
            for (int it = 0; it < 60; it++) begin
                int          op;
                int          ak;
                logic [31:0] a;
                op = int'($urandom_range(0, 9));
                ak = int'($urandom_range(0, 5));
                if (ak == 0)      a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                else if (ak == 1) a = {22'h0, 8'($urandom_range(16, 255)), 2'b00};
                else              a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                if (op == 0 && d > 0)
                    abort_xfer(d, a, $urandom);
                else if (op <= 1)
                    idle(int'($urandom_range(1, 3)));
                else
                    xfer(d, 1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), rd, er, lat);
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
